// File: rtl/cdc_stable_capture_pkg.sv
// rtl/cdc_stable_capture_pkg.sv - shared types and helpers for the stable-capture block
// Purpose: FSM state type and the stability counter width helper.
// Ports: none (package).
package cdc_stable_capture_pkg;

  typedef enum logic {IDLE, HOLD} stab_state_e;

  // Counter must hold the value STABLE_CYC itself, hence the +1.
  function automatic int cnt_width(input int stable_cyc);
    return $clog2(stable_cyc + 1);
  endfunction

endpackage

// File: rtl/cdc_stable_capture_if.sv
// rtl/cdc_stable_capture_if.sv - valid/ready output bus of the stable-capture block
// Purpose: groups the qualified-value handshake.
// Ports (signals): dout[DW] qualified value, dout_vld value available,
//   dout_rdy consumer accepts on dout_vld && dout_rdy at posedge.
// Modports: master (producer side), slave (consumer side).
interface cdc_stable_capture_if #(
  parameter int DW = 32
) ();

  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          dout_rdy;

  modport master (output dout, output dout_vld, input dout_rdy);
  modport slave  (input dout, input dout_vld, output dout_rdy);

endinterface

// File: rtl/cdc_stable_capture_stab_det.sv
// rtl/cdc_stable_capture_stab_det.sv - stability detector for a bit-wise synchronised bus
// Purpose: registers din, compares against the previous sample and counts
//   consecutive equal comparisons, saturating at STABLE_CYC.
// Ports: clk, rst (sync, active-high), din[DW] in;
//   din_q[DW] registered sample, qual (din_q stable for STABLE_CYC compares),
//   chg (din differs from din_q this cycle) out.
module cdc_stable_capture_stab_det
  import cdc_stable_capture_pkg::*;
#(
  parameter int DW         = 32,
  parameter int STABLE_CYC = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] din_q,
  output logic          qual,
  output logic          chg
);

  localparam int            CW   = cnt_width(STABLE_CYC);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYC);

  logic [CW-1:0] cnt;
  logic          eq;

  assign eq   = (din == din_q);
  assign chg  = !eq;
  assign qual = (cnt == CMAX);

  // Reset loads CMAX so the reset value 0 already counts as qualified.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_q <= '0;
      cnt   <= CMAX;
    end else begin
      din_q <= din;
      if (!eq)
        cnt <= '0;
      else if (cnt != CMAX)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cdc_stable_capture.sv
// rtl/cdc_stable_capture.sv - qualifies a synchronised bus and delivers each new value once
// Purpose: accepts a value only after STABLE_CYC equal comparisons, hands each
//   new qualified value out once on a valid/ready bus, counts transients.
// Ports: clk, rst (sync, active-high), din[DW] synchronised bus in;
//   m (master modport: dout[DW], dout_vld out, dout_rdy in);
//   glitch_cnt[GW] saturating count of values replaced before qualifying.
module cdc_stable_capture
  import cdc_stable_capture_pkg::*;
#(
  parameter int DW         = 32,
  parameter int STABLE_CYC = 3,
  parameter int GW         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         din,
  cdc_stable_capture_if.master  m,
  output logic [GW-1:0]         glitch_cnt
);

  logic [DW-1:0] din_q;
  logic [DW-1:0] last_out;
  logic          qual;
  logic          chg;
  stab_state_e   state;

  cdc_stable_capture_stab_det #(
    .DW         (DW),
    .STABLE_CYC (STABLE_CYC)
  ) u_det (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .din_q (din_q),
    .qual  (qual),
    .chg   (chg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      m.dout     <= '0;
      m.dout_vld <= 1'b0;
      last_out   <= '0;
      glitch_cnt <= '0;
    end else begin
      // A change while unqualified means the previous value was transient.
      if (chg && !qual && (glitch_cnt != '1))
        glitch_cnt <= glitch_cnt + 1'b1;

      case (state)
        IDLE: begin
          // Last-value semantics: whatever is qualified now is what gets sent.
          if (qual && (din_q != last_out)) begin
            m.dout     <= din_q;
            last_out   <= din_q;
            m.dout_vld <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (m.dout_rdy) begin
            m.dout_vld <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_stable_capture.sv
// tb/tb_cdc_stable_capture.sv - directed self-checking bench for cdc_stable_capture
module tb_cdc_stable_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        rdy;
  logic [15:0] gcnt;
  logic [3:0]  gcnt_s;

  int          checks   = 0;
  int          failures = 0;
  int          n;
  logic [31:0] dq[$];

  always #5 clk = ~clk;

  cdc_stable_capture_if #(.DW(32)) bus ();
  cdc_stable_capture_if #(.DW(32)) bus_s ();

  assign bus.dout_rdy   = rdy;
  assign bus_s.dout_rdy = 1'b1;

  cdc_stable_capture #(.DW(32), .STABLE_CYC(3), .GW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .m          (bus),
    .glitch_cnt (gcnt)
  );

  cdc_stable_capture #(.DW(32), .STABLE_CYC(3), .GW(4)) dut_s (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .m          (bus_s),
    .glitch_cnt (gcnt_s)
  );

  // Scoreboard of delivered values (handshake completes at the next posedge).
  always @(negedge clk)
    if (!rst && bus.dout_vld && bus.dout_rdy)
      dq.push_back(bus.dout);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    din = 32'h0;
    rdy = 1'b1;
    repeat (3) tick();
    check("rst_vld", 32'(bus.dout_vld), 32'h0);
    check("rst_dout", bus.dout, 32'h0);
    check("rst_glitch", 32'(gcnt), 32'h0);

    // Release with din held at 0: nothing is delivered.
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("zero_vld", 32'(bus.dout_vld), 32'h0);
    end
    check("zero_glitch", 32'(gcnt), 32'h0);
    check("zero_deliv", 32'(dq.size()), 32'h0);

    // Latency: din first sampled at edge k, vld only after edge k+4.
    din = 32'hDEADBEEF;
    tick();
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("lat_early_vld", 32'(bus.dout_vld), 32'h0);
    end
    tick();
    check("lat_vld", 32'(bus.dout_vld), 32'h1);
    check("lat_dout", bus.dout, 32'hDEADBEEF);
    tick();
    check("lat_pulse_end", 32'(bus.dout_vld), 32'h0);
    check("lat_deliv_n", 32'(dq.size()), 32'h1);
    check("lat_deliv_v", dq[0], 32'hDEADBEEF);

    // Toggle every 2 cycles for 20 cycles: never qualifies, 9 glitches.
    for (int i = 0; i < 10; i++) begin
      din = (i % 2 == 0) ? 32'hA5A5A5A5 : 32'h5A5A5A5A;
      tick();
      check("tog_vld", 32'(bus.dout_vld), 32'h0);
      tick();
      check("tog_vld", 32'(bus.dout_vld), 32'h0);
    end
    check("tog_glitch", 32'(gcnt), 32'd9);
    check("tog_glitch_s", 32'(gcnt_s), 32'd9);
    n = dq.size();
    repeat (10) tick();
    check("tog_hold_n", 32'(dq.size() - n), 32'h1);
    check("tog_hold_v", dq[$], 32'h5A5A5A5A);

    // Backpressure: 0x1 held, 0x2 overwrites, one-cycle gap after accept.
    rdy = 1'b0;
    din = 32'h1;
    repeat (6) tick();
    check("bp_vld1", 32'(bus.dout_vld), 32'h1);
    check("bp_dout1", bus.dout, 32'h1);
    din = 32'h2;
    repeat (6) tick();
    check("bp_hold_vld", 32'(bus.dout_vld), 32'h1);
    check("bp_hold_dout", bus.dout, 32'h1);
    n = dq.size();
    rdy = 1'b1;
    tick();
    check("bp_gap_vld", 32'(bus.dout_vld), 32'h0);
    check("bp_acc1_n", 32'(dq.size() - n), 32'h1);
    check("bp_acc1_v", dq[$], 32'h1);
    tick();
    check("bp_vld2", 32'(bus.dout_vld), 32'h1);
    check("bp_dout2", bus.dout, 32'h2);
    tick();
    check("bp_end_vld", 32'(bus.dout_vld), 32'h0);
    check("bp_acc2_n", 32'(dq.size() - n), 32'h2);
    check("bp_acc2_v", dq[$], 32'h2);
    check("bp_glitch", 32'(gcnt), 32'd9);

    // 20 forced glitches: 4-bit counter saturates at 15, 16-bit reaches 29.
    for (int i = 0; i <= 20; i++) begin
      din = (i % 2 == 1) ? 32'h4 : 32'h3;
      tick();
      if (i == 6)
        check("sat_reach", 32'(gcnt_s), 32'd15);
    end
    check("sat_small", 32'(gcnt_s), 32'd15);
    check("sat_big", 32'(gcnt), 32'd29);
    repeat (8) tick();
    check("sat_nowrap", 32'(gcnt_s), 32'd15);
    check("sat_deliv_v", dq[$], 32'h3);

    // Reset during HOLD discards pending value; 0x77 redelivered once.
    rdy = 1'b0;
    din = 32'h77;
    repeat (6) tick();
    check("rh_vld", 32'(bus.dout_vld), 32'h1);
    check("rh_dout", bus.dout, 32'h77);
    n = dq.size();
    rst = 1'b1;
    tick();
    check("rh_rst_vld", 32'(bus.dout_vld), 32'h0);
    check("rh_rst_dout", bus.dout, 32'h0);
    check("rh_rst_glitch", 32'(gcnt), 32'h0);
    rst = 1'b0;
    rdy = 1'b1;
    repeat (12) tick();
    check("rh_redeliv_n", 32'(dq.size() - n), 32'h1);
    check("rh_redeliv_v", dq[$], 32'h77);
    check("rh_glitch", 32'(gcnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
